// File: rtl/fetch_queue.sv
// Dual-lane show-ahead instruction buffer between fetch and decode.
// Accepts up to two instructions per cycle and presents the two oldest to decode.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          valid_f_0,
  input  logic          valid_f_1,
  input  logic [31:0]   instr_f_0,
  input  logic [31:0]   instr_f_1,
  input  logic [31:0]   pc_plus_8_f_0,
  input  logic [31:0]   pc_plus_8_f_1,
  input  logic [1:0]    deq_d,
  output logic          enq_ready,
  output logic          valid_q_0,
  output logic          valid_q_1,
  output logic [31:0]   instr_q_0,
  output logic [31:0]   instr_q_1,
  output logic [31:0]   pc_plus_8_q_0,
  output logic [31:0]   pc_plus_8_q_1,
  output logic [AW:0]   count
);

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    n_in, n_out, deq_eff;
  logic [AW-1:0] head_p1, tail_lane1;
  logic          do_enq;

  // enq_ready looks only at registered occupancy, keeping decode off the fetch path
  assign enq_ready = (count_q <= (AW+1)'(DEPTH - 2));
  assign do_enq    = enq_ready && !flush && !reset;

  always_comb begin
    n_in    = do_enq ? (2'(valid_f_0) + 2'(valid_f_1)) : 2'd0;
    deq_eff = (deq_d == 2'd3) ? 2'd2 : deq_d;
    n_out   = (count_q < (AW+1)'(deq_eff)) ? count_q[1:0] : deq_eff;
  end

  always_comb begin
    head_d  = head_q + AW'(n_out);
    tail_d  = tail_q + AW'(n_in);
    count_d = count_q + (AW+1)'(n_in) - (AW+1)'(n_out);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Lane 1 lands right after lane 0, or at tail itself when lane 0 is empty
  assign tail_lane1 = tail_q + AW'(valid_f_0);

  always_ff @(posedge clk) begin
    if (do_enq) begin
      if (valid_f_0) begin
        instr_mem[tail_q] <= instr_f_0;
        pc_mem[tail_q]    <= pc_plus_8_f_0;
      end
      if (valid_f_1) begin
        instr_mem[tail_lane1] <= instr_f_1;
        pc_mem[tail_lane1]    <= pc_plus_8_f_1;
      end
    end
  end

  assign head_p1 = head_q + AW'(1);

  always_comb begin
    valid_q_0     = (count_q >= (AW+1)'(1));
    valid_q_1     = (count_q >= (AW+1)'(2));
    instr_q_0     = valid_q_0 ? instr_mem[head_q]  : '0;
    pc_plus_8_q_0 = valid_q_0 ? pc_mem[head_q]     : '0;
    instr_q_1     = valid_q_1 ? instr_mem[head_p1] : '0;
    pc_plus_8_q_1 = valid_q_1 ? pc_mem[head_p1]    : '0;
    count         = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset, flush, valid_f_0, valid_f_1;
  logic [31:0] instr_f_0, instr_f_1, pc_plus_8_f_0, pc_plus_8_f_1;
  logic [1:0]  deq_d;
  logic        enq_ready, valid_q_0, valid_q_1;
  logic [31:0] instr_q_0, instr_q_1, pc_plus_8_q_0, pc_plus_8_q_1;
  logic [AW:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_f_0(valid_f_0), .valid_f_1(valid_f_1),
    .instr_f_0(instr_f_0), .instr_f_1(instr_f_1),
    .pc_plus_8_f_0(pc_plus_8_f_0), .pc_plus_8_f_1(pc_plus_8_f_1),
    .deq_d(deq_d), .enq_ready(enq_ready),
    .valid_q_0(valid_q_0), .valid_q_1(valid_q_1),
    .instr_q_0(instr_q_0), .instr_q_1(instr_q_1),
    .pc_plus_8_q_0(pc_plus_8_q_0), .pc_plus_8_q_1(pc_plus_8_q_1),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {instr, pc+8}, oldest at index 0
  logic [63:0] mq[$];

  always @(posedge clk) begin
    int n_out, sz;
    bit rdy;
    if (reset || flush) begin
      mq.delete();
    end else begin
      sz    = mq.size();
      rdy   = (DEPTH - sz) >= 2;
      n_out = (deq_d == 2'd3) ? 2 : int'(deq_d);
      if (n_out > sz) n_out = sz;
      for (int i = 0; i < n_out; i++) void'(mq.pop_front());
      if (rdy) begin
        if (valid_f_0) mq.push_back({instr_f_0, pc_plus_8_f_0});
        if (valid_f_1) mq.push_back({instr_f_1, pc_plus_8_f_1});
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e0, e1;
    if (chk_en) begin
      e0 = (mq.size() >= 1) ? mq[0] : 64'd0;
      e1 = (mq.size() >= 2) ? mq[1] : 64'd0;
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_enq_ready", 32'(enq_ready), 32'((DEPTH - mq.size()) >= 2));
      chk("m_valid0", 32'(valid_q_0), 32'(mq.size() >= 1));
      chk("m_valid1", 32'(valid_q_1), 32'(mq.size() >= 2));
      chk("m_instr0", instr_q_0, e0[63:32]);
      chk("m_pc0", pc_plus_8_q_0, e0[31:0]);
      chk("m_instr1", instr_q_1, e1[63:32]);
      chk("m_pc1", pc_plus_8_q_1, e1[31:0]);
    end
  end

  task automatic cyc(input bit v0, input bit v1, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [1:0] dq, input bit fl);
    valid_f_0 = v0; valid_f_1 = v1;
    instr_f_0 = i0; instr_f_1 = i1;
    pc_plus_8_f_0 = i0 + 32'h1000; pc_plus_8_f_1 = i1 + 32'h1000;
    deq_d = dq; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; valid_f_0 = 1'b0; valid_f_1 = 1'b0;
    instr_f_0 = '0; instr_f_1 = '0; pc_plus_8_f_0 = '0; pc_plus_8_f_1 = '0; deq_d = '0;
    @(posedge clk); @(negedge clk);
    idle();
    reset = 1'b0;
    chk_en = 1'b1;
    idle();
    chk("rst_valid0", 32'(valid_q_0), 32'd0);
    chk("rst_valid1", 32'(valid_q_1), 32'd0);
    chk("rst_instr0", instr_q_0, 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    cyc(1'b1, 1'b1, 32'h11, 32'h22, 2'd0, 1'b0);
    chk("push_instr0", instr_q_0, 32'h11);
    chk("push_instr1", instr_q_1, 32'h22);
    chk("push_pc0", pc_plus_8_q_0, 32'h1011);
    chk("push_count", 32'(count), 32'd2);

    for (int unsigned k = 0; k < 3; k++)
      cyc(1'b1, 1'b1, 32'h30 + 32'(2*k), 32'h31 + 32'(2*k), 2'd0, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd1, 1'b0);
    chk("c7_count", 32'(count), 32'd7);
    chk("c7_enq_ready", 32'(enq_ready), 32'd0);
    chk("c7_head", instr_q_0, 32'h22);
    cyc(1'b1, 1'b1, 32'hEE, 32'hEF, 2'd0, 1'b0);
    chk("blocked_count", 32'(count), 32'd7);

    cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'hA, 32'd0, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 32'hB, 32'hC, 2'd2, 1'b0);
    chk("deq2_count", 32'(count), 32'd2);
    chk("deq2_instr0", instr_q_0, 32'hB);
    chk("deq2_instr1", instr_q_1, 32'hC);

    cyc(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 32'd0, 32'h55, 2'd3, 1'b0);
    chk("lane1_instr0", instr_q_0, 32'h55);
    chk("lane1_valid1", 32'(valid_q_1), 32'd0);
    chk("lane1_count", 32'(count), 32'd1);

    cyc(1'b1, 1'b1, 32'h61, 32'h62, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 32'h63, 32'h64, 2'd0, 1'b0);
    chk("c5_count", 32'(count), 32'd5);
    cyc(1'b1, 1'b1, 32'h71, 32'h72, 2'd2, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid0", 32'(valid_q_0), 32'd0);
    cyc(1'b1, 1'b1, 32'h73, 32'h74, 2'd0, 1'b1);
    chk("flush2_count", 32'(count), 32'd0);

    for (int unsigned k = 0; k < 300; k++) begin
      if (k == 150) reset = 1'b1;
      cyc(1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom),
          ($urandom_range(0, 31) == 0));
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
